// File: rtl/axicb_write_scheduler_if.sv
// Write-path handshake bundle between the crossbar masters, one slave port
// and the scheduler. The "master" modport is the scheduler's view because
// the scheduler is the side that drives the slave's AW/W and the masters' B.
// The "slave" modport is the view of the masters and the slave port.
interface axicb_write_scheduler_if #(
  parameter int MST_NB = 4
);
  logic [MST_NB-1:0] mst_awvalid;
  logic [MST_NB-1:0] mst_awready;
  logic              slv_awvalid;
  logic              slv_awready;
  logic [MST_NB-1:0] aw_sel;

  logic [MST_NB-1:0] mst_wvalid;
  logic [MST_NB-1:0] mst_wlast;
  logic [MST_NB-1:0] mst_wready;
  logic              slv_wvalid;
  logic              slv_wlast;
  logic              slv_wready;
  logic [MST_NB-1:0] w_sel;

  logic              slv_bvalid;
  logic              slv_bready;
  logic [MST_NB-1:0] mst_bvalid;
  logic [MST_NB-1:0] mst_bready;
  logic [MST_NB-1:0] b_sel;

  modport master (
    input  mst_awvalid, slv_awready,
    output mst_awready, slv_awvalid, aw_sel,
    input  mst_wvalid, mst_wlast, slv_wready,
    output mst_wready, slv_wvalid, slv_wlast, w_sel,
    input  slv_bvalid, mst_bready,
    output slv_bready, mst_bvalid, b_sel
  );

  modport slave (
    output mst_awvalid, slv_awready,
    input  mst_awready, slv_awvalid, aw_sel,
    output mst_wvalid, mst_wlast, slv_wready,
    input  mst_wready, slv_wvalid, slv_wlast, w_sel,
    output slv_bvalid, mst_bready,
    input  slv_bready, mst_bvalid, b_sel
  );
endinterface

// File: rtl/axicb_write_scheduler.sv
// Write-path scheduler for one crossbar slave port.
// A round-robin arbiter picks the next AW; the granted master index is pushed
// into two in-order FIFOs that steer W beats and B responses back to the
// owning master. Only handshakes and one-hot selects are produced here.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | no AW presented to the slave; arbitrate when FIFOs have room
//   S_BUSY | granted AW presented to the slave, waiting for slv_awready
module axicb_write_scheduler #(
  parameter int MST_NB      = 4,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                  aclk_i,
  input  logic                  srst_i,
  axicb_write_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(MST_NB);
  localparam int PTR_W = $clog2(OSTDREQ_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OSTDREQ_NUM);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic [MST_NB-1:0] mask_q, mask_d;
  logic [MST_NB-1:0] aw_sel_q, aw_sel_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;

  logic [MST_NB-1:0] masked_req;
  logic              masked_hit;
  logic [IDX_W-1:0]  grant_idx;
  logic              fifo_push;

  logic [IDX_W-1:0]  w_mem_q [OSTDREQ_NUM];
  logic [PTR_W-1:0]  w_wr_q, w_rd_q;
  logic [CNT_W-1:0]  w_cnt_q;
  logic              w_empty, w_full, w_pop;
  logic [IDX_W-1:0]  w_head;

  logic [IDX_W-1:0]  b_mem_q [OSTDREQ_NUM];
  logic [PTR_W-1:0]  b_wr_q, b_rd_q;
  logic [CNT_W-1:0]  b_cnt_q;
  logic              b_empty, b_full, b_pop;
  logic [IDX_W-1:0]  b_head;

  // Round-robin pick: lowest requester at or above the mask, else wrap to lowest overall
  always_comb begin
    masked_req = mask_q & bus.mst_awvalid;
    masked_hit = 1'b0;
    grant_idx  = '0;
    for (int i = MST_NB - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        grant_idx  = IDX_W'(i);
        masked_hit = 1'b1;
      end
    end
    if (!masked_hit) begin
      for (int i = MST_NB - 1; i >= 0; i--) begin
        if (bus.mst_awvalid[i]) grant_idx = IDX_W'(i);
      end
    end
  end

  // AW FSM state, grant and round-robin mask registers
  always_ff @(posedge aclk_i) begin
    if (srst_i) begin
      state_q  <= S_IDLE;
      mask_q   <= '1;
      aw_sel_q <= '0;
      aw_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      aw_sel_q <= aw_sel_d;
      aw_idx_q <= aw_idx_d;
    end
  end

  // AW FSM next state: grant only when both FIFOs can take the new index
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    aw_sel_d  = aw_sel_q;
    aw_idx_d  = aw_idx_q;
    fifo_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        aw_sel_d = '0;
        if (|bus.mst_awvalid && !w_full && !b_full) begin
          aw_sel_d = MST_NB'(1) << grant_idx;
          aw_idx_d = grant_idx;
          for (int i = 0; i < MST_NB; i++) begin
            mask_d[i] = (i > int'(grant_idx));
          end
          if (grant_idx == IDX_W'(MST_NB - 1)) mask_d = '1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.slv_awready) begin
          fifo_push = 1'b1;
          aw_sel_d  = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        aw_sel_d = '0;
      end
    endcase
  end

  assign bus.slv_awvalid = (state_q == S_BUSY);
  assign bus.aw_sel      = aw_sel_q;
  assign bus.mst_awready = aw_sel_q & {MST_NB{bus.slv_awready}};

  assign w_empty = (w_cnt_q == '0);
  assign w_full  = (w_cnt_q == FULL_CNT);
  assign w_head  = w_mem_q[w_rd_q];
  assign w_pop   = !w_empty && bus.mst_wvalid[w_head] && bus.slv_wready
                   && bus.mst_wlast[w_head];

  // W index FIFO: entries leave on the last beat of the owning burst
  always_ff @(posedge aclk_i) begin
    if (srst_i) begin
      w_wr_q  <= '0;
      w_rd_q  <= '0;
      w_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        w_mem_q[w_wr_q] <= aw_idx_q;
        w_wr_q          <= w_wr_q + PTR_W'(1);
      end
      if (w_pop) w_rd_q <= w_rd_q + PTR_W'(1);
      if (fifo_push && !w_pop)      w_cnt_q <= w_cnt_q + CNT_W'(1);
      else if (!fifo_push && w_pop) w_cnt_q <= w_cnt_q - CNT_W'(1);
    end
  end

  // W steering: only the head master may talk to the slave
  always_comb begin
    bus.w_sel      = '0;
    bus.slv_wvalid = 1'b0;
    bus.slv_wlast  = 1'b0;
    bus.mst_wready = '0;
    if (!w_empty) begin
      bus.w_sel      = MST_NB'(1) << w_head;
      bus.slv_wvalid = bus.mst_wvalid[w_head];
      bus.slv_wlast  = bus.mst_wlast[w_head];
      bus.mst_wready = (MST_NB'(1) << w_head) & {MST_NB{bus.slv_wready}};
    end
  end

  assign b_empty = (b_cnt_q == '0);
  assign b_full  = (b_cnt_q == FULL_CNT);
  assign b_head  = b_mem_q[b_rd_q];
  assign b_pop   = !b_empty && bus.slv_bvalid && bus.mst_bready[b_head];

  // B index FIFO: entries leave on each accepted response
  always_ff @(posedge aclk_i) begin
    if (srst_i) begin
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        b_mem_q[b_wr_q] <= aw_idx_q;
        b_wr_q          <= b_wr_q + PTR_W'(1);
      end
      if (b_pop) b_rd_q <= b_rd_q + PTR_W'(1);
      if (fifo_push && !b_pop)      b_cnt_q <= b_cnt_q + CNT_W'(1);
      else if (!fifo_push && b_pop) b_cnt_q <= b_cnt_q - CNT_W'(1);
    end
  end

  // B steering: a response with no outstanding write is held off
  always_comb begin
    bus.b_sel      = '0;
    bus.mst_bvalid = '0;
    bus.slv_bready = 1'b0;
    if (!b_empty) begin
      bus.b_sel      = MST_NB'(1) << b_head;
      bus.mst_bvalid = (MST_NB'(1) << b_head) & {MST_NB{bus.slv_bvalid}};
      bus.slv_bready = bus.mst_bready[b_head];
    end
  end

endmodule
